star_frame_loader: RTL and testbench
====================================

Name: star_frame_loader

Overview:
Upstream feeder for the combinational star-to-delta converter.
- Receives the three star-arm resistances as a serial stream of W-bit elements over a valid/ready handshake.
- Assembles them into a frame and rejects frames containing a zero arm, since every arm is a divisor downstream.
- Holds the accepted frame stable on star_out, with a valid/ready handshake, until the consumer takes it.

Parameters:
W, 4, width of one star-arm value; matches the converter's element width.
TIMEOUT, 16, idle cycles allowed between elements inside a frame before the frame is aborted.
CNT_W, 8, width of the good-frame counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_data  input  W  star-arm value
in_valid  input  1  in_data valid
in_sof  input  1  marks first element (arm 0) of a frame; qualified by in_valid
in_ready  output  1  loader can accept an element this cycle
star_out  output  W x [2:0] unpacked array  assembled arms, index = arm number
out_valid  output  1  star_out holds an accepted frame
out_ready  input  1  consumer takes the frame
err_zero  output  1  one-cycle pulse: frame dropped, some arm == 0
err_frame  output  1  one-cycle pulse: framing error (missing sof, restart, timeout)
frame_cnt  output  CNT_W  count of frames handed off, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, idx 0, timer 0, all star_out elements 0, out_valid 0, err_zero 0, err_frame 0, frame_cnt 0, in_ready 0 while rst is high.
- Accept: an element is accepted when in_valid && in_ready.
- in_ready is 1 in IDLE and COLLECT, 0 in PRESENT and while rst is high.
- States: IDLE, COLLECT, PRESENT.
- IDLE:
  - Accepted element with in_sof: store in slot 0, idx <= 1, go to COLLECT.
  - Accepted element without in_sof: discard it, pulse err_frame, stay in IDLE.
- COLLECT:
  - Accepted element with in_sof: restart. Store in slot 0, idx <= 1, pulse err_frame, stay in COLLECT.
  - Accepted element without in_sof: store in slot idx, idx <= idx+1.
  - On acceptance of the slot-2 element, the zero check covers slots 0, 1 and the incoming value.
    - All nonzero: copy the three slots to star_out, go to PRESENT.
    - Any zero: pulse err_zero, star_out unchanged, go to IDLE.
- Timer:
  - Counts COLLECT cycles with no acceptance and clears on every acceptance.
  - When it reaches TIMEOUT: go to IDLE, pulse err_frame, clear the timer.
  - Acceptance and expiry in the same cycle: acceptance wins, no error.
- PRESENT:
  - out_valid = 1; star_out held stable; input stalled.
  - On out_ready: out_valid is 0 from the next cycle, frame_cnt increments, go to IDLE.
- Latency: out_valid and the new star_out are visible in the cycle after the third element is accepted.
- Consumer handshake: a frame can be taken in its first valid cycle, so minimum frame period is 4 cycles.
- Output stability: star_out changes only on entry to PRESENT. Dropped or aborted frames never disturb it.
- Counter: frame_cnt wraps from 2^CNT_W-1 to 0 without flagging.
- err_zero and err_frame are mutually exclusive in any cycle.
- Reset mid-frame or in PRESENT: everything returns to reset values on the next edge; any partial frame is lost.

Decomposition:
- Package star_delta_pkg holds:
  - W default and NUM_ARMS = 3.
  - The state enum type (IDLE, COLLECT, PRESENT).
  - The star-array typedef, which the converter also adopts.
- One natural sub-module: idle_timer, a clearable up-counter with an expiry flag parameterised by TIMEOUT. Everything else stays in star_frame_loader.

Test Plan:
- Good frame: sof+3, 4, 6 on consecutive cycles, out_ready held 1 -> out_valid in cycle 4, star_out = {6,4,3} (arm2..arm0), frame_cnt = 1, in_ready = 0 for exactly one cycle.
- Zero arm: sof+5, 0, 7 -> err_zero pulses once, out_valid stays 0, star_out keeps the previous frame values.
- Framing: element 9 without sof in IDLE -> err_frame pulse, no state change. Then sof+2, sof+8, 1, 1 -> err_frame on the second sof, frame {1,1,8} presented.
- Backpressure and timeout:
  - out_ready low for 10 cycles after frame {2,2,2} -> star_out stable, in_ready 0 throughout.
  - sof+3 followed by 16 idle cycles -> err_frame, back to IDLE.
  - Element arriving on the expiry cycle -> accepted, no error.
- Reset and wrap:
  - rst asserted after the second element -> all outputs at reset values next cycle; the first frame after reset presents correctly.
  - 256 good frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/star_delta_pkg.sv
// Shared types for the star-to-delta datapath: element width, arm count,
// loader state encoding and the star-array type used by loader and converter.
package star_delta_pkg;

   localparam int unsigned STAR_W   = 4;
   localparam int unsigned NUM_ARMS = 3;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      PRESENT
   } load_state_t;

   typedef logic [STAR_W-1:0] star_arr_t [NUM_ARMS-1:0];

endpackage

// File: rtl/star_frame_loader_idle_timer.sv
// Clearable up-counter that flags the cycle in which the TIMEOUT-th
// consecutive increment happens.
module idle_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] count;

   // Count idle cycles; clear has priority over increment.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   // Expiry is signalled on the idle cycle that would bring the count to TIMEOUT.
   assign expired = inc && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/star_frame_loader.sv
// Serial-to-frame loader for the star-to-delta converter: collects three
// arm values, drops frames with a zero arm, and holds accepted frames on
// star_out until the consumer takes them.
module star_frame_loader
   import star_delta_pkg::*;
#(
   parameter int unsigned W       = STAR_W,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic             in_ready,
   output logic [W-1:0]     star_out [NUM_ARMS-1:0],
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_zero,
   output logic             err_frame,
   output logic [CNT_W-1:0] frame_cnt
);

   load_state_t      state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [W-1:0]     slot_q [2];
   logic [W-1:0]     slot_d [2];
   logic [W-1:0]     star_d [NUM_ARMS-1:0];
   logic             err_zero_d, err_frame_d;
   logic [CNT_W-1:0] cnt_d;
   logic             accept;
   logic             tmr_clr, tmr_inc, tmr_expired;

   assign in_ready  = !rst && (state_q != PRESENT);
   assign out_valid = (state_q == PRESENT);
   assign accept    = in_valid && in_ready;

   // Timer only runs while a frame is being collected and no element arrives.
   assign tmr_inc = (state_q == COLLECT) && !accept;
   assign tmr_clr = (state_q != COLLECT) || accept || tmr_expired;

   idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   // Next-state, slot capture, zero check and error pulse generation.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      slot_d      = slot_q;
      star_d      = star_out;
      err_zero_d  = 1'b0;
      err_frame_d = 1'b0;
      cnt_d       = frame_cnt;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_sof) begin
                  slot_d[0] = in_data;
                  idx_d     = 2'd1;
                  state_d   = COLLECT;
               end else begin
                  err_frame_d = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (accept) begin
               if (in_sof) begin
                  slot_d[0]   = in_data;
                  idx_d       = 2'd1;
                  err_frame_d = 1'b1;
               end else if (idx_q == 2'd2) begin
                  // Third arm is checked straight off the bus, not from a slot.
                  if ((slot_q[0] != '0) && (slot_q[1] != '0) && (in_data != '0)) begin
                     star_d[0] = slot_q[0];
                     star_d[1] = slot_q[1];
                     star_d[2] = in_data;
                     state_d   = PRESENT;
                  end else begin
                     err_zero_d = 1'b1;
                     state_d    = IDLE;
                  end
                  idx_d = 2'd0;
               end else begin
                  slot_d[1] = in_data;
                  idx_d     = 2'd2;
               end
            end else if (tmr_expired) begin
               err_frame_d = 1'b1;
               idx_d       = 2'd0;
               state_d     = IDLE;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               cnt_d   = frame_cnt + 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= 2'd0;
         slot_q    <= '{default: '0};
         star_out  <= '{default: '0};
         err_zero  <= 1'b0;
         err_frame <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         slot_q    <= slot_d;
         star_out  <= star_d;
         err_zero  <= err_zero_d;
         err_frame <= err_frame_d;
         frame_cnt <= cnt_d;
      end
   end

endmodule

// File: tb/tb_star_frame_loader.sv
// Self-checking bench for star_frame_loader: directed scenarios followed by
// randomized traffic, all checked against a frame-level reference model.
module tb_star_frame_loader;

   localparam int W       = 4;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   logic             clk;
   logic             rst;
   logic [W-1:0]     in_data;
   logic             in_valid;
   logic             in_sof;
   logic             in_ready;
   logic [W-1:0]     star_out [2:0];
   logic             out_valid;
   logic             out_ready;
   logic             err_zero;
   logic             err_frame;
   logic [CNT_W-1:0] frame_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: collected elements, presented frame, counters.
   int m_buf[$];
   bit m_present;
   int m_idle;
   int m_star[3];
   bit m_ez, m_ef;
   int m_cnt;

   star_frame_loader #(
      .W       (W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_ready  (in_ready),
      .star_out  (star_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_zero  (err_zero),
      .err_frame (err_frame),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_buf.delete();
      m_present = 1'b0;
      m_idle    = 0;
      m_star    = '{0, 0, 0};
      m_ez      = 1'b0;
      m_ef      = 1'b0;
      m_cnt     = 0;
   endtask

   // One clock of frame-level behaviour.
   task automatic model_step(input bit r, input bit v, input bit s, input int d, input bit ordy);
      bit acc;
      if (r) begin
         model_reset();
         return;
      end
      m_ez = 1'b0;
      m_ef = 1'b0;
      acc  = v && !m_present;
      if (m_present) begin
         if (ordy) begin
            m_present = 1'b0;
            m_cnt     = (m_cnt + 1) % (1 << CNT_W);
         end
      end else if (acc) begin
         m_idle = 0;
         if (s) begin
            if (m_buf.size() > 0) m_ef = 1'b1;
            m_buf.delete();
            m_buf.push_back(d);
         end else if (m_buf.size() == 0) begin
            m_ef = 1'b1;
         end else begin
            m_buf.push_back(d);
            if (m_buf.size() == 3) begin
               if (m_buf[0] != 0 && m_buf[1] != 0 && m_buf[2] != 0) begin
                  for (int i = 0; i < 3; i++) m_star[i] = m_buf[i];
                  m_present = 1'b1;
               end else begin
                  m_ez = 1'b1;
               end
               m_buf.delete();
            end
         end
      end else if (m_buf.size() > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_ef = 1'b1;
            m_buf.delete();
            m_idle = 0;
         end
      end else begin
         m_idle = 0;
      end
   endtask

   task automatic check_outputs(input bit r);
      check("in_ready",  {31'd0, in_ready},  {31'd0, !r && !m_present});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_present});
      check("err_zero",  {31'd0, err_zero},  {31'd0, m_ez});
      check("err_frame", {31'd0, err_frame}, {31'd0, m_ef});
      check("err_excl",  {31'd0, err_zero && err_frame}, 32'd0);
      check("frame_cnt", {24'd0, frame_cnt}, m_cnt);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("star_out[%0d]", i), {28'd0, star_out[i]}, m_star[i]);
      end
   endtask

   // Drive one cycle of inputs, check this cycle's outputs, advance model and clock.
   task automatic cyc(input bit r, input bit v, input bit s, input int d, input bit ordy);
      rst       = r;
      in_valid  = v;
      in_sof    = s;
      in_data   = d[W-1:0];
      out_ready = ordy;
      #1;
      check_outputs(r);
      model_step(r, v, s, d, ordy);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, ordy);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int vprob;
      int cnt_before;
      bit v, s, o, r;
      int d;

      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 5, 1);

      // Good frame with consumer always ready
      cyc(0, 1, 1, 3, 1);
      cyc(0, 1, 0, 4, 1);
      cyc(0, 1, 0, 6, 1);
      check("good_valid", {31'd0, out_valid}, 32'd1);
      check("good_arm2", {28'd0, star_out[2]}, 32'd6);
      check("good_arm1", {28'd0, star_out[1]}, 32'd4);
      check("good_arm0", {28'd0, star_out[0]}, 32'd3);
      idle(2, 1);
      check("good_cnt", {24'd0, frame_cnt}, 32'd1);

      // Zero arm: frame dropped, previous frame kept
      cyc(0, 1, 1, 5, 1);
      cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 0, 7, 1);
      check("zero_pulse", {31'd0, err_zero}, 32'd1);
      check("zero_keep", {28'd0, star_out[0]}, 32'd3);
      idle(2, 1);

      // Framing errors: element without sof, then restart on second sof
      cyc(0, 1, 0, 9, 1);
      cyc(0, 1, 1, 2, 1);
      cyc(0, 1, 1, 8, 1);
      cyc(0, 1, 0, 1, 1);
      cyc(0, 1, 0, 1, 1);
      idle(2, 1);

      // Backpressure: hold frame {2,2,2} for 10 cycles
      cyc(0, 1, 1, 2, 0);
      cyc(0, 1, 0, 2, 0);
      cyc(0, 1, 0, 2, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, i[0], 3, 0);
      cyc(0, 0, 0, 0, 1);
      idle(2, 1);

      // Timeout after 16 idle cycles
      cyc(0, 1, 1, 3, 1);
      idle(TIMEOUT + 2, 1);

      // Element arriving on the expiry cycle is accepted
      cyc(0, 1, 1, 3, 1);
      idle(TIMEOUT - 1, 1);
      cyc(0, 1, 0, 5, 1);
      cyc(0, 1, 0, 7, 1);
      idle(3, 1);

      // Reset mid-frame, then a clean frame
      cyc(0, 1, 1, 1, 1);
      cyc(0, 1, 0, 2, 1);
      cyc(1, 1, 0, 3, 1);
      cyc(0, 1, 1, 7, 1);
      cyc(0, 1, 0, 8, 1);
      cyc(0, 1, 0, 9, 1);
      idle(2, 1);

      // 256 back-to-back frames wrap the counter back to its start value
      cnt_before = m_cnt;
      for (int i = 0; i < 256; i++) begin
         cyc(0, 1, 1, (i % 15) + 1, 1);
         cyc(0, 1, 0, 1, 1);
         cyc(0, 1, 0, 15, 1);
         cyc(0, 0, 0, 0, 1);
      end
      check("wrap_cnt", {24'd0, frame_cnt}, cnt_before);

      // Randomized traffic
      vprob = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) vprob = $urandom_range(100, 8);
         v = ($urandom_range(99) < vprob);
         s = ($urandom_range(99) < 30);
         d = ($urandom_range(5) == 0) ? 0 : $urandom_range(15);
         o = ($urandom_range(99) < 60);
         r = ($urandom_range(799) == 0);
         cyc(r, v, s, d, o);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
